// File: rtl/enc_6b8b_pkg.sv
// Shared constants, state encoding and CRC-6 step function for the 6b8b
// encoder front-end and the decoder-side lock checker.
package enc_6b8b_pkg;

  localparam logic [5:0] K_IDLE = 6'b000111;
  localparam logic [5:0] K_SOF  = 6'b111000;
  localparam logic [5:0] K_EOF  = 6'b010101;
  localparam logic [5:0] K_SYNC = 6'b101010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_DATA = 3'd2,
    ST_CRC  = 3'd3,
    ST_EOF  = 3'd4
  } state_e;

  typedef struct packed {
    logic [5:0] din;
    logic       kischar;
  } sym_t;

  // x^6 + x + 1, low-order taps only; the x^6 term is the shifted-out MSB
  localparam logic [5:0] CRC6_POLY = 6'h03;
  localparam logic [5:0] CRC6_INIT = 6'h3F;

  function automatic logic [5:0] crc6_next(input logic [5:0] crc, input logic [5:0] data);
    logic [5:0] c;
    logic       fb;
    c = crc;
    for (int i = 5; i >= 0; i--) begin
      fb = c[5] ^ data[i];
      c  = {c[4:0], 1'b0} ^ (fb ? CRC6_POLY : 6'h00);
    end
    return c;
  endfunction

endpackage

// File: rtl/enc_6b8b_sync_timer.sv
// Free-running symbol-slot counter; flags the last slot of each
// SYNC_INTERVAL period. SYNC_INTERVAL=0 never flags.
module enc_6b8b_sync_timer #(
  parameter int SYNC_INTERVAL = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic sync_due
);

  generate
    if (SYNC_INTERVAL == 0) begin : g_off
      logic w_unused_in;
      assign w_unused_in = clk ^ rst ^ tick;
      assign sync_due    = 1'b0;
    end else begin : g_on
      localparam int CW = (SYNC_INTERVAL > 1) ? $clog2(SYNC_INTERVAL) : 1;
      localparam logic [CW-1:0] LAST = CW'(SYNC_INTERVAL - 1);

      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_cnt <= '0;
        end else if (tick) begin
          r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
      end

      assign sync_due = (r_cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/enc_6b8b_sched.sv
// Symbol scheduler feeding the 6b8b encoder: SOF/EOF framing, IDLE fill,
// periodic SYNC. Optional CRC-6 slot before EOF: ENC_6B8B_SCHED_CRC_EN.
module enc_6b8b_sched
  import enc_6b8b_pkg::*;
#(
  parameter int SYNC_INTERVAL = 16,
  parameter int MAX_LEN       = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [5:0] enc_din,
  output logic       enc_kischar,
  output logic       busy,
  output logic       frame_err
);

  localparam int WCW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(MAX_LEN - 1);

`ifdef ENC_6B8B_SCHED_CRC_EN
  localparam state_e ST_CLOSE = ST_CRC;
`else
  localparam state_e ST_CLOSE = ST_EOF;
`endif

  state_e         r_state, w_state_nx;
  logic [WCW-1:0] r_wcnt, w_wcnt_nx;
  sym_t           r_sym, w_sym;
  logic           r_ferr, w_ferr_nx;
  logic           w_sync_due;
  logic           w_xfer;

  // One symbol leaves every cycle, so the sync period advances unconditionally
  enc_6b8b_sync_timer #(
    .SYNC_INTERVAL(SYNC_INTERVAL)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .tick     (1'b1),
    .sync_due (w_sync_due)
  );

  assign s_ready = (r_state == ST_DATA) && !w_sync_due;
  assign w_xfer  = s_valid && s_ready;

`ifdef ENC_6B8B_SCHED_CRC_EN
  logic [5:0] r_crc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_crc <= CRC6_INIT;
    end else if (!w_sync_due && r_state == ST_SOF) begin
      r_crc <= CRC6_INIT;
    end else if (w_xfer) begin
      r_crc <= crc6_next(r_crc, s_data);
    end
  end
`endif

  // SYNC pre-empts the slot; the state machine holds so nothing is lost
  always_comb begin
    w_sym      = '{din: K_IDLE, kischar: 1'b1};
    w_state_nx = r_state;
    w_wcnt_nx  = r_wcnt;
    w_ferr_nx  = 1'b0;
    if (w_sync_due) begin
      w_sym = '{din: K_SYNC, kischar: 1'b1};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en && s_valid) w_state_nx = ST_SOF;
        end
        ST_SOF: begin
          w_sym      = '{din: K_SOF, kischar: 1'b1};
          w_wcnt_nx  = '0;
          w_state_nx = ST_DATA;
        end
        ST_DATA: begin
          if (w_xfer) begin
            w_sym     = '{din: s_data, kischar: 1'b0};
            w_wcnt_nx = r_wcnt + WCW'(1);
            if (s_last) begin
              w_state_nx = ST_CLOSE;
            end else if (r_wcnt == WLAST) begin
              w_state_nx = ST_CLOSE;
              w_ferr_nx  = 1'b1;
            end
          end
        end
`ifdef ENC_6B8B_SCHED_CRC_EN
        ST_CRC: begin
          w_sym      = '{din: r_crc, kischar: 1'b0};
          w_state_nx = ST_EOF;
        end
`endif
        ST_EOF: begin
          w_sym      = '{din: K_EOF, kischar: 1'b1};
          w_state_nx = ST_IDLE;
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
      r_sym   <= '{din: K_IDLE, kischar: 1'b1};
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_wcnt  <= w_wcnt_nx;
      r_sym   <= w_sym;
      r_ferr  <= w_ferr_nx;
    end
  end

  assign enc_din     = r_sym.din;
  assign enc_kischar = r_sym.kischar;
  assign busy        = (r_state != ST_IDLE);
  assign frame_err   = r_ferr;

endmodule

// File: tb/tb_enc_6b8b_sched.sv
// Scoreboarded bench for enc_6b8b_sched: stream-level framing model feeds an
// expected-symbol queue; an independent monitor checks every output symbol.
module tb_enc_6b8b_sched;
  import enc_6b8b_pkg::*;

  localparam int SI = 16;
  localparam int ML = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [5:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready, enc_kischar, busy, frame_err;
  logic [5:0] enc_din;

  enc_6b8b_sched #(.SYNC_INTERVAL(SI), .MAX_LEN(ML)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .enc_din     (enc_din),
    .enc_kischar (enc_kischar),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] sym;
    logic       k;
    logic       ferr;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rdy_cnt = 0;

  // stream-level model: position within the current frame and running CRC
  int   m_cnt = 0;
  int   m_crc = 'h3F;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [5:0] sym, input logic k, input logic ferr);
    exp_t e;
    e.sym = sym; e.k = k; e.ferr = ferr;
    return e;
  endfunction

  // Polynomial division one message bit at a time (x^6 term = 0x40)
  function automatic int crc_word(input int crc, input logic [5:0] w);
    int r;
    r = crc;
    for (int b = 5; b >= 0; b--) begin
      r = r ^ (int'(w[b]) << 5);
      r = (r & 'h20) != 0 ? ((r << 1) ^ 'h43) & 'h3F : (r << 1) & 'h3F;
    end
    return r;
  endfunction

  task automatic model_word(input logic [5:0] d, input logic last);
    logic [5:0] c;
    if (m_cnt == 0) begin
      q.push_back(mk(K_SOF, 1'b1, 1'b0));
      m_crc = 'h3F;
    end
    m_cnt++;
    m_crc = crc_word(m_crc, d);
    q.push_back(mk(d, 1'b0, !last && m_cnt == ML));
    if (last || m_cnt == ML) begin
      c = m_crc[5:0];
`ifdef ENC_6B8B_SCHED_CRC_EN
      q.push_back(mk(c, 1'b0, 1'b0));
`endif
      q.push_back(mk(K_EOF, 1'b1, 1'b0));
      m_cnt = 0;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [5:0] d, input logic last, input int gap);
    bit acc;
    bit start;
    int t;
    acc = 0; t = 0;
    cycles(gap);
    start = (m_cnt == 0);
    model_word(d, last);
    s_data = d; s_last = last; s_valid = 1'b1;
    en = start ? 1'b1 : 1'($urandom_range(0, 1));
    do begin
      @(negedge clk); acc = s_ready; t++;
      @(posedge clk); #1;
    end while (!acc && t < 200);
    if (!acc) chk("handshake_timeout", 32'd0, 32'd1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while ((q.size() != 0 || busy) && t < 500);
    chk("drain_timeout", 32'(q.size() != 0 || busy), 32'd0);
    @(posedge clk); #1;
    cycles(2);
  endtask

  // Monitor: outputs sampled at negedge reflect the preceding posedge
  int         sym_idx = 0;
  bit         prev_rst_n = 0, prev_xfer = 0, after_eof = 0;
  logic [5:0] prev_data = '0;

  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!prev_rst_n) begin
        chk("reset_state", {busy, frame_err, s_ready, enc_kischar, 2'b00, enc_din},
            {4'b0001, 2'b00, K_IDLE});
        sym_idx = 0; after_eof = 0;
        q.delete();
      end else begin
        if (sym_idx % SI == SI - 1) begin
          chk("sync_slot", {frame_err, enc_kischar, enc_din}, {1'b0, 1'b1, K_SYNC});
        end else begin
          if (after_eof) begin
            chk("idle_after_eof", {enc_kischar, enc_din}, {1'b1, K_IDLE});
            after_eof = 0;
          end
          if (enc_kischar && enc_din == K_IDLE) begin
            chk("idle_ferr", 32'(frame_err), 32'd0);
          end else if (q.size() == 0) begin
            chk("unexpected_sym", {enc_kischar, enc_din}, {1'b1, K_IDLE});
          end else begin
            e = q.pop_front();
            chk("symbol", {frame_err, enc_kischar, enc_din}, {e.ferr, e.k, e.sym});
            chk("busy", 32'(busy), 32'(!(e.k && e.sym == K_EOF)));
            after_eof = e.k && e.sym == K_EOF;
          end
        end
        if (prev_xfer) chk("latency", {enc_kischar, enc_din}, {1'b0, prev_data});
        sym_idx++;
      end
      if (rst) begin
        chk("ready_rule", 32'(s_ready && (!busy || sym_idx % SI == SI - 1)), 32'd0);
        if (s_ready) rdy_cnt++;
      end
      prev_rst_n = rst;
      prev_xfer  = rst && s_valid && s_ready;
      prev_data  = s_data;
    end
  end

  initial begin
    int len;
    cycles(3);
    rst = 1'b1;
    cycles(40);

    // en low must gate frame start even with valid data waiting
    s_data = 6'h1A; s_valid = 1'b1;
    cycles(20);
    chk("en_gate", 32'(busy), 32'd0);
    s_valid = 1'b0;
    cycles(2);

    rdy_cnt = 0;
    send_word(6'h01, 1'b0, 0);
    send_word(6'h02, 1'b0, 0);
    send_word(6'h03, 1'b1, 0);
    wait_drain();
    chk("ready_cycles", 32'(rdy_cnt), 32'd3);

    send_word(6'h0A, 1'b0, 0);
    send_word(6'h0B, 1'b1, 2);
    wait_drain();

    // overlong stream: forced close after ML words, rest starts a new frame
    for (int w = 0; w < 7; w++) send_word(6'(6'h20 + w), w == 6, 0);
    wait_drain();

    send_word(6'h11, 1'b0, 0);
    send_word(6'h12, 1'b0, 0);
    rst = 1'b0;
    cycles(1);
    rst = 1'b1;
    m_cnt = 0;
    cycles(3);
    @(negedge clk);
    chk("post_reset_busy", {busy, enc_kischar, enc_din}, {1'b0, 1'b1, K_IDLE});
    @(posedge clk); #1;

    send_word(6'h3F, 1'b1, 0);
    wait_drain();

    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 7);
      for (int w = 0; w < len; w++)
        send_word(6'($urandom), w == len - 1, (w == 0) ? 0 : $urandom_range(0, 2));
      cycles($urandom_range(0, 3));
    end
    wait_drain();
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/enc_6b8b_sched.md
Name: enc_6b8b_sched

Overview:
- Symbol scheduler that sequences the 6b8b encoder (enc_6b8b).
- Takes 6-bit payload words over a valid/ready stream with frame delimiting.
- Drives exactly one symbol per clk into the encoder's din/KisChar inputs.
- Frames payload with K_SOF/K_EOF, fills gaps with K_IDLE and periodically forces K_SYNC so the receiver can hold symbol lock.

Parameters:
- K_IDLE, 6'b000111: idle/fill K-character.
- K_SOF, 6'b111000: start-of-frame K-character.
- K_EOF, 6'b010101: end-of-frame K-character.
- K_SYNC, 6'b101010: periodic sync K-character.
- SYNC_INTERVAL, 16: number of symbols per sync period (the last slot of each period is K_SYNC). 0 disables sync insertion.
- MAX_LEN, 64: maximum payload words per frame before a forced EOF.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: synchronous, active-low reset.
- en, input, 1: allows a new frame to start. Does not abort a frame in progress.
- s_data, input, 6: payload word.
- s_valid, input, 1: s_data is valid.
- s_last, input, 1: the current word is the last of the frame.
- s_ready, output, 1: scheduler accepts the word this cycle.
- enc_din, output, 6: symbol to the encoder's din.
- enc_kischar, output, 1: 1 when enc_din is a K-character.
- busy, output, 1: a frame is in progress (any state other than IDLE).
- frame_err, output, 1: one-cycle pulse when MAX_LEN forces EOF.

Behaviour:
- Reset (rst=0 at posedge):
  - enc_din=K_IDLE, enc_kischar=1, s_ready=0, busy=0, frame_err=0.
  - state=IDLE, sync counter=0, word counter=0.
  - Reset mid-frame abandons the frame with no EOF.
- Output timing:
  - enc_din/enc_kischar are registered. The symbol chosen in cycle t appears after posedge t+1.
  - An accepted word reaches enc_din with 1-cycle latency.
- s_ready is combinational and high only when state=DATA and sync_due=0. A transfer occurs when s_valid&&s_ready. s_data must be held stable while s_valid=1 and s_ready=0.
- Sync counter:
  - Increments on every emitted symbol and wraps at SYNC_INTERVAL-1.
  - sync_due=1 when the counter is SYNC_INTERVAL-1; that slot emits K_SYNC (kischar=1).
  - K_SYNC has top priority. A pending SOF/EOF/CRC slips one cycle, and the state does not advance.
- States:
  - IDLE: emit K_IDLE. If en&&s_valid, go to SOF.
  - SOF: emit K_SOF, clear the word counter, go to DATA.
  - DATA: on a transfer, emit s_data with kischar=0 and increment the word counter. With no transfer, emit K_IDLE as fill.
    - A transfer with s_last=1 goes to EOF (or CRC when the optional feature is enabled).
    - A transfer that brings the word counter to MAX_LEN without s_last goes to EOF with frame_err pulsed. Upstream's later words start a new frame.
  - EOF: emit K_EOF, go to IDLE.
- Deasserting en mid-frame has no effect until the frame returns to IDLE.
- Back-to-back frames: one K_IDLE is always emitted between K_EOF and the next K_SOF.
- SYNC_INTERVAL=0: sync_due is tied to 0.
- The counter widths are $clog2 of their parameter, minimum 1.

Optional Feature:
- Macro: ENC_6B8B_SCHED_CRC_EN.
- Defined:
  - A CRC state sits between DATA and EOF and emits one data symbol (kischar=0) holding CRC-6 over all accepted words of the frame.
  - CRC definition: polynomial x^6+x+1, init 6'h3F, MSB-first, no final XOR.
  - The CRC slot is subject to K_SYNC slip like any other slot.
  - On a forced EOF (MAX_LEN), the CRC is still emitted.
- Undefined: DATA goes directly to EOF; no CRC logic is synthesised.

Decomposition:
- Package enc_6b8b_pkg holds:
  - the K-character constants;
  - the state enum (IDLE, SOF, DATA, CRC, EOF);
  - the CRC6 polynomial/init constants and a crc6_next function.
- Sub-module enc_6b8b_sync_timer:
  - Parameterised SYNC_INTERVAL counter with inputs clk, rst, tick and output sync_due.
  - Reused by the decoder-side lock checker.

Test Plan:
- Reset with en=0, s_valid=0 → enc_din=000111, kischar=1 on every cycle except every 16th symbol, which is 101010.
- en=1, one frame of 3 words (01,02,03, last on 03), s_valid continuous → 111000(K), 01,02,03 (kischar=0), 010101(K), then 000111; s_ready high for exactly 3 cycles.
- Frame whose payload would span sync slot 15 → 101010 inserted between payload words, s_ready low for that cycle, no word lost or duplicated.
- s_valid gaps mid-frame (word, gap ×2, word+last) → two K_IDLE fill symbols between the payload words; frame closes with K_EOF.
- MAX_LEN=4, stream 6 words with no s_last → K_EOF after word 4, frame_err pulse for 1 cycle, words 5–6 framed by a new K_SOF.
- rst=0 asserted for 1 cycle in the middle of DATA → next symbols are K_IDLE, busy=0, no K_EOF emitted. With ENC_6B8B_SCHED_CRC_EN, frame {3F} → the CRC symbol equals crc6_next(6'h3F, 6'h3F).
